// File: rtl/ascii2bcd_pack.sv
// ASCII decimal byte stream to right-justified packed BCD, with start/done handshake to the converter.
// Optional build macro ASCII2BCD_SPACE_TERM_EN: treat space (0x20) as a line terminator.
module ascii2bcd_pack #(
    parameter int DIGITS = 3,
    localparam int CW = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic [DIGITS*4-1:0]   bcd_out,
    output logic [CW-1:0]         ndigits,
    output logic                  conv_start,
    input  logic                  conv_done,
    output logic                  frame_err
);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_DISCARD = 2'd1;
    localparam logic [1:0] S_START   = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [CW-1:0] ND_MAX = CW'(DIGITS);

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic logic is_term(input logic [7:0] b);
`ifdef ASCII2BCD_SPACE_TERM_EN
        return (b == 8'h0D) || (b == 8'h0A) || (b == 8'h20);
`else
        return (b == 8'h0D) || (b == 8'h0A);
`endif
    endfunction

    logic [1:0]           state_r;
    logic [1:0]           next_state_s;
    logic [DIGITS*4-1:0]  next_bcd_s;
    logic [CW-1:0]        next_nd_s;
    logic                 next_err_s;
    logic                 next_start_s;
    logic                 accept_s;
    logic                 digit_s;
    logic                 term_s;

    assign in_ready = (state_r == S_COLLECT) || (state_r == S_DISCARD);
    assign accept_s = in_valid & in_ready;
    assign digit_s  = is_digit(in_data);
    assign term_s   = is_term(in_data);

    // Next-state and datapath decode for the frame parser.
    always_comb begin
        next_state_s = state_r;
        next_bcd_s   = bcd_out;
        next_nd_s    = ndigits;
        next_err_s   = 1'b0;
        case (state_r)
            S_COLLECT: begin
                if (accept_s) begin
                    if (digit_s) begin
                        if (ndigits < ND_MAX) begin
                            next_bcd_s = {bcd_out[DIGITS*4-5:0], in_data[3:0]};
                            next_nd_s  = ndigits + CW'(1);
                        end else begin
                            next_err_s   = 1'b1;
                            next_state_s = S_DISCARD;
                        end
                    end else if (term_s) begin
                        // An empty line is silently skipped rather than starting a zero-digit conversion.
                        if (ndigits != '0) begin
                            next_state_s = S_START;
                        end else begin
                            next_state_s = S_COLLECT;
                        end
                    end else begin
                        next_err_s   = 1'b1;
                        next_state_s = S_DISCARD;
                    end
                end else begin
                    next_state_s = S_COLLECT;
                end
            end
            S_DISCARD: begin
                if (accept_s && term_s) begin
                    next_state_s = S_COLLECT;
                    next_bcd_s   = '0;
                    next_nd_s    = '0;
                end else begin
                    next_state_s = S_DISCARD;
                end
            end
            S_START: begin
                if (conv_done) begin
                    next_state_s = S_RELEASE;
                end else begin
                    next_state_s = S_START;
                end
            end
            S_RELEASE: begin
                if (!conv_done) begin
                    next_state_s = S_COLLECT;
                    next_bcd_s   = '0;
                    next_nd_s    = '0;
                end else begin
                    next_state_s = S_RELEASE;
                end
            end
            default: begin
                next_state_s = S_COLLECT;
                next_bcd_s   = '0;
                next_nd_s    = '0;
            end
        endcase
        next_start_s = (next_state_s == S_START);
    end

    // State and registered outputs; reset clears everything, including a pending conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_COLLECT;
            bcd_out    <= '0;
            ndigits    <= '0;
            conv_start <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            bcd_out    <= next_bcd_s;
            ndigits    <= next_nd_s;
            conv_start <= next_start_s;
            frame_err  <= next_err_s;
        end
    end

endmodule

// File: tb/tb_ascii2bcd_pack.sv
// Scoreboard bench for ascii2bcd_pack: driver pushes expected events, negedge monitor pops and compares.
module tb_ascii2bcd_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [11:0] bcd_out;
    logic [1:0]  ndigits;
    logic        conv_start;
    logic        conv_done;
    logic        frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int conv_lat = 2;
    int cnt;

    typedef struct {
        bit          is_err;
        logic [11:0] bcd;
        logic [1:0]  nd;
        int          bin;
    } ev_t;
    ev_t exp_q[$];

    logic start_prev = 1'b0;
    logic done_prev = 1'b0;

    ascii2bcd_pack #(.DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .bcd_out(bcd_out), .ndigits(ndigits),
        .conv_start(conv_start), .conv_done(conv_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Converter model: done rises conv_lat cycles into a start, falls one cycle after start drops.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_done <= 1'b0;
            cnt <= 0;
        end else if (!conv_start) begin
            conv_done <= 1'b0;
            cnt <= 0;
        end else if (cnt >= conv_lat) begin
            conv_done <= 1'b1;
        end else begin
            cnt <= cnt + 1;
        end
    end

    function automatic int bcd2bin(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input bit is_err, input logic [11:0] bcd, input logic [1:0] nd, input int bin);
        ev_t e;
        e.is_err = is_err;
        e.bcd = bcd;
        e.nd = nd;
        e.bin = bin;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input bit is_err);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got %s with bcd 0x%0h, expected none",
                     is_err ? "frame_err" : "conv_start", bcd_out);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(is_err), 32'(e.is_err));
            check("event_bcd", 32'(bcd_out), 32'(e.bcd));
            check("event_ndigits", 32'(ndigits), 32'(e.nd));
            if (!is_err) begin
                check("event_bin", bcd2bin(bcd_out), e.bin);
            end
        end
    endtask

    // Monitor: one event per frame_err pulse and per conv_start rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) pop_check(1'b1);
            if (conv_start && !start_prev) pop_check(1'b0);
            if (done_prev && start_prev) check("start_drop", 32'(conv_start), 32'd0);
        end
        start_prev = conv_start;
        done_prev = conv_done;
    end

    task automatic send(input logic [7:0] b);
        int t;
        in_valid = 1'b1;
        in_data = b;
        t = 0;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: byte 0x%0h not accepted, expected acceptance", b);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(in_ready && !conv_start && !conv_done) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: in_ready %0b conv_start %0b, expected 1 0", in_ready, conv_start);
        end
    endtask

    initial begin
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_ndigits", 32'(ndigits), 32'd0);
        check("rst_conv_start", 32'(conv_start), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal three-digit frame
        push(1'b0, 12'h123, 2'd3, 123);
        send(8'h31); send(8'h32); send(8'h33);
        check("t1_bcd_pre", 32'(bcd_out), 32'h123);
        check("t1_nd_pre", 32'(ndigits), 32'd3);
        send(8'h0D);
        check("t1_start_latency", 32'(conv_start), 32'd1);
        check("t1_ready_low", 32'(in_ready), 32'd0);
        wait_idle();
        check("t1_bcd_clear", 32'(bcd_out), 32'd0);
        check("t1_nd_clear", 32'(ndigits), 32'd0);

        // Digit overflow, then recovery
        push(1'b1, 12'h456, 2'd3, 0);
        push(1'b0, 12'h008, 2'd1, 8);
        send(8'h34); send(8'h35); send(8'h36); send(8'h37);
        check("t2_err_pulse", 32'(frame_err), 32'd1);
        send(8'h0D);
        check("t2_err_one_cycle", 32'(frame_err), 32'd0);
        check("t2_bcd_after_cr", 32'(bcd_out), 32'd0);
        check("t2_no_start", 32'(conv_start), 32'd0);
        send(8'h38); send(8'h0A);
        check("t2_start", 32'(conv_start), 32'd1);
        check("t2_bcd", 32'(bcd_out), 32'h008);
        wait_idle();

        // Illegal character mid-frame
        push(1'b1, 12'h001, 2'd1, 0);
        send(8'h31); send(8'h41); send(8'h32); send(8'h0D);
        check("t3_bcd", 32'(bcd_out), 32'd0);
        check("t3_nd", 32'(ndigits), 32'd0);
        check("t3_ready", 32'(in_ready), 32'd1);
        check("t3_no_start", 32'(conv_start), 32'd0);

        // Empty lines
        send(8'h0D); send(8'h0A);
        @(negedge clk);
        check("t4_ready", 32'(in_ready), 32'd1);
        check("t4_no_start", 32'(conv_start), 32'd0);
        check("t4_no_err", 32'(frame_err), 32'd0);

        // Slow converter: word held, next byte stalled
        conv_lat = 10;
        push(1'b0, 12'h099, 2'd2, 99);
        push(1'b0, 12'h005, 2'd1, 5);
        send(8'h39); send(8'h39); send(8'h0D);
        for (int i = 0; i < 10; i++) begin
            check("t5_ready_low", 32'(in_ready), 32'd0);
            check("t5_bcd_hold", 32'(bcd_out), 32'h099);
            @(negedge clk);
        end
        send(8'h35);
        check("t5_nd_after", 32'(ndigits), 32'd1);
        check("t5_bcd_after", 32'(bcd_out), 32'h005);
        conv_lat = 2;
        send(8'h0A);
        wait_idle();

        // Space handling depends on build option
`ifdef ASCII2BCD_SPACE_TERM_EN
        push(1'b0, 12'h007, 2'd1, 7);
        send(8'h37); send(8'h20);
        check("t6_space_start", 32'(conv_start), 32'd1);
        wait_idle();
`else
        push(1'b1, 12'h007, 2'd1, 0);
        send(8'h37); send(8'h20);
        check("t6_space_err", 32'(frame_err), 32'd1);
        send(8'h0D);
        check("t6_bcd", 32'(bcd_out), 32'd0);
`endif

        // Asynchronous reset during a conversion
        conv_lat = 20;
        push(1'b0, 12'h005, 2'd1, 5);
        send(8'h35); send(8'h0D);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t7_start_clr", 32'(conv_start), 32'd0);
        check("t7_bcd_clr", 32'(bcd_out), 32'd0);
        check("t7_nd_clr", 32'(ndigits), 32'd0);
        check("t7_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        conv_lat = 2;
        push(1'b0, 12'h000, 2'd1, 0);
        send(8'h30); send(8'h0D);
        check("t7_start", 32'(conv_start), 32'd1);
        check("t7_bcd", 32'(bcd_out), 32'd0);
        wait_idle();

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
